// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: IEEE 1149.1 TAP state encodings, scan controller states,
// preamble length and the TAP next-state function.
package jtag_pkg;

  typedef enum logic [3:0] {
    TAP_TLR       = 4'd0,
    TAP_RTI       = 4'd1,
    TAP_SEL_DR    = 4'd2,
    TAP_CAP_DR    = 4'd3,
    TAP_SHIFT_DR  = 4'd4,
    TAP_EXIT1_DR  = 4'd5,
    TAP_PAUSE_DR  = 4'd6,
    TAP_EXIT2_DR  = 4'd7,
    TAP_UPDATE_DR = 4'd8,
    TAP_SEL_IR    = 4'd9,
    TAP_CAP_IR    = 4'd10,
    TAP_SHIFT_IR  = 4'd11,
    TAP_EXIT1_IR  = 4'd12,
    TAP_PAUSE_IR  = 4'd13,
    TAP_EXIT2_IR  = 4'd14,
    TAP_UPDATE_IR = 4'd15
  } tap_state_e;

  // Each scan state names the TAP state occupied while its TMS value is presented.
  typedef enum logic [3:0] {
    ST_PRE,
    ST_IDLE,
    ST_SEL_DR,
    ST_SEL_IR,
    ST_CAPTURE,
    ST_SHIFT,
    ST_EXIT1,
    ST_UPDATE,
    ST_RTI,
    ST_RESP
  } ctrl_state_e;

  localparam int unsigned PRE_LEN = 5;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    case (s)
      TAP_TLR:       return tms ? TAP_TLR       : TAP_RTI;
      TAP_RTI:       return tms ? TAP_SEL_DR    : TAP_RTI;
      TAP_SEL_DR:    return tms ? TAP_SEL_IR    : TAP_CAP_DR;
      TAP_CAP_DR:    return tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_SHIFT_DR:  return tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_EXIT1_DR:  return tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR:  return tms ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
      TAP_EXIT2_DR:  return tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
      TAP_UPDATE_DR: return tms ? TAP_SEL_DR    : TAP_RTI;
      TAP_SEL_IR:    return tms ? TAP_TLR       : TAP_CAP_IR;
      TAP_CAP_IR:    return tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_SHIFT_IR:  return tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_EXIT1_IR:  return tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR:  return tms ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
      TAP_EXIT2_IR:  return tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
      TAP_UPDATE_IR: return tms ? TAP_SEL_DR    : TAP_RTI;
      default:       return TAP_TLR;
    endcase
  endfunction

endpackage

// File: rtl/jtag_tap_track.sv
// TAP state mirror: follows the TMS stream the TAP sees and reports its current state.
module jtag_tap_track
  import jtag_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tms,
  output logic [3:0] tap_state
);

  tap_state_e tap_q;
  tap_state_e tap_d;

  always_comb begin
    tap_d = tap_next(tap_q, tms);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_q <= TAP_TLR;
    end else begin
      tap_q <= tap_d;
    end
  end

  assign tap_state = tap_q;

endmodule

// File: rtl/jtag_scan_ctrl.sv
// JTAG scan controller: walks the TAP through IR/DR scans of up to DW bits from Run-Test/Idle.
// Define JTAG_TDO_CAPTURE_EN to capture TDO into rsp_data and return it via a response handshake.
module jtag_scan_ctrl
  import jtag_pkg::*;
#(
  parameter  int unsigned DW = 8,
  localparam int unsigned LW = $clog2(DW)
) (
  input  logic          TCK,
  input  logic          RST,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_ir,
  input  logic [LW-1:0] cmd_len,
  input  logic [DW-1:0] cmd_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          TMS,
  output logic          TDI,
  input  logic          TDO,
  output logic [3:0]    tap_state
);

  localparam int unsigned PCW = $clog2(PRE_LEN + 1);

  ctrl_state_e    state_q, state_d;
  logic [PCW-1:0] pre_cnt_q, pre_cnt_d;
  logic [LW-1:0]  bit_q, bit_d;
  logic           tms_q, tms_d;
  logic           tdi_q, tdi_d;
  logic           ir_q, ir_d;
  logic [LW-1:0]  len_q, len_d;
  logic [DW-1:0]  data_q, data_d;
`ifdef JTAG_TDO_CAPTURE_EN
  logic [DW-1:0]  rsp_q, rsp_d;
`endif

  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    bit_d     = bit_q;
    ir_d      = ir_q;
    len_d     = len_q;
    data_d    = data_q;
`ifdef JTAG_TDO_CAPTURE_EN
    rsp_d     = rsp_q;
`endif

    case (state_q)
      ST_PRE: begin
        if (pre_cnt_q == PCW'(PRE_LEN)) begin
          state_d = ST_IDLE;
        end else begin
          pre_cnt_d = pre_cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (cmd_valid) begin
          ir_d    = cmd_ir;
          len_d   = cmd_len;
          data_d  = cmd_data;
          state_d = ST_RTI;
`ifdef JTAG_TDO_CAPTURE_EN
          rsp_d   = '0;
`endif
        end
      end
      ST_RTI:     state_d = ST_SEL_DR;
      ST_SEL_DR:  state_d = ir_q ? ST_SEL_IR : ST_CAPTURE;
      ST_SEL_IR:  state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        state_d = ST_SHIFT;
        bit_d   = '0;
      end
      ST_SHIFT: begin
`ifdef JTAG_TDO_CAPTURE_EN
        rsp_d[bit_q] = TDO;
`endif
        if (bit_q == len_q) begin
          state_d = ST_EXIT1;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      ST_EXIT1: state_d = ST_UPDATE;
`ifdef JTAG_TDO_CAPTURE_EN
      ST_UPDATE: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
`else
      ST_UPDATE: state_d = ST_IDLE;
`endif
      default: state_d = ST_PRE;
    endcase

    // TMS/TDI are registered, so they are derived from the state being entered.
    tms_d = 1'b0;
    tdi_d = 1'b0;
    case (state_d)
      ST_PRE:    tms_d = (pre_cnt_d < PCW'(PRE_LEN));
      ST_RTI:    tms_d = 1'b1;
      ST_SEL_DR: tms_d = ir_d;
      ST_SHIFT: begin
        tms_d = (bit_d == len_d);
        tdi_d = data_d[bit_d];
      end
      ST_EXIT1:  tms_d = 1'b1;
      default:   tms_d = 1'b0;
    endcase
  end

  always_ff @(posedge TCK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_PRE;
      pre_cnt_q <= '0;
      bit_q     <= '0;
      tms_q     <= 1'b1;
      tdi_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      bit_q     <= bit_d;
      tms_q     <= tms_d;
      tdi_q     <= tdi_d;
    end
  end

  // Command fields are only meaningful once accepted, so they carry no reset.
  always_ff @(posedge TCK) begin
    ir_q   <= ir_d;
    len_q  <= len_d;
    data_q <= data_d;
  end

`ifdef JTAG_TDO_CAPTURE_EN
  always_ff @(posedge TCK or posedge RST) begin
    if (RST) begin
      rsp_q <= '0;
    end else begin
      rsp_q <= rsp_d;
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rsp_q;
`else
  logic unused_inputs;
  assign unused_inputs = rsp_ready ^ TDO;
  assign rsp_valid     = 1'b0;
  assign rsp_data      = '0;
`endif

  assign cmd_ready = (state_q == ST_IDLE);
  assign TMS       = tms_q;
  assign TDI       = tdi_q;

  jtag_tap_track u_tap_track (
    .clk       (TCK),
    .rst       (RST),
    .tms       (tms_q),
    .tap_state (tap_state)
  );

endmodule

// File: tb/tb_jtag_scan_ctrl.sv
// Scoreboard bench: jtag_scan_ctrl driving a behavioural TAP with a 4-bit IR,
// a 5-bit register at IR=5, a 7-bit register at IR=7 and bypass otherwise.
`timescale 1ns/1ps
module tb_jtag_scan_ctrl;

  localparam int DW = 8;
  localparam int LW = 3;

  logic          TCK = 1'b0;
  logic          RST = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ir = 1'b0;
  logic [LW-1:0] cmd_len = '0;
  logic [DW-1:0] cmd_data = '0;
  logic          rsp_ready = 1'b0;
  logic          cmd_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          TMS;
  logic          TDI;
  logic          TDO;
  logic [3:0]    tap_state;

  int n_cmp = 0;
  int n_bad = 0;
  bit track_en = 1'b0;

  bit            exp_tms[$];
  bit            exp_tdi[$];
  logic [DW-1:0] exp_rsp[$];

  always #5 TCK = ~TCK;

  jtag_scan_ctrl #(.DW(DW)) dut (
    .TCK       (TCK),
    .RST       (RST),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_ir    (cmd_ir),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .TMS       (TMS),
    .TDI       (TDI),
    .TDO       (TDO),
    .tap_state (tap_state)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural TAP
  logic [3:0] m_st  = 4'd0;
  logic [3:0] m_ir  = 4'h1;
  logic [4:0] m_r5  = 5'b01001;
  logic [6:0] m_r7  = 7'h5A;
  logic [6:0] m_sr  = 7'd0;
  int         m_len = 1;

  assign TDO = m_sr[0];

  function automatic logic [3:0] m_next(input logic [3:0] s, input logic t);
    case (s)
      4'd0:    return t ? 4'd0  : 4'd1;
      4'd1:    return t ? 4'd2  : 4'd1;
      4'd2:    return t ? 4'd9  : 4'd3;
      4'd3:    return t ? 4'd5  : 4'd4;
      4'd4:    return t ? 4'd5  : 4'd4;
      4'd5:    return t ? 4'd8  : 4'd6;
      4'd6:    return t ? 4'd7  : 4'd6;
      4'd7:    return t ? 4'd8  : 4'd4;
      4'd8:    return t ? 4'd2  : 4'd1;
      4'd9:    return t ? 4'd0  : 4'd10;
      4'd10:   return t ? 4'd12 : 4'd11;
      4'd11:   return t ? 4'd12 : 4'd11;
      4'd12:   return t ? 4'd15 : 4'd13;
      4'd13:   return t ? 4'd14 : 4'd13;
      4'd14:   return t ? 4'd15 : 4'd11;
      default: return t ? 4'd2  : 4'd1;
    endcase
  endfunction

  always @(posedge TCK) begin : tap_model
    logic       t;
    logic [6:0] nsr;
    t   = (TMS !== 1'b0);
    nsr = m_sr;
    case (m_st)
      4'd0: m_ir <= 4'h1;
      4'd3: begin
        if (m_ir == 4'd5) begin
          m_len <= 5;
          nsr = {2'b00, m_r5};
        end else if (m_ir == 4'd7) begin
          m_len <= 7;
          nsr = m_r7;
        end else begin
          m_len <= 1;
          nsr = 7'd0;
        end
      end
      4'd4, 4'd11: begin
        nsr = m_sr >> 1;
        nsr[m_len-1] = TDI;
      end
      4'd8: begin
        if (m_ir == 4'd5) m_r5 <= m_sr[4:0];
        else if (m_ir == 4'd7) m_r7 <= m_sr;
      end
      4'd10: begin
        m_len <= 4;
        nsr = {3'b000, m_ir};
      end
      4'd15: m_ir <= m_sr[3:0];
      default: ;
    endcase
    m_sr <= nsr;
    m_st <= m_next(m_st, t);
  end

  always @(negedge TCK) begin
    if (track_en) check_val("tap_track", 32'(tap_state), 32'(m_st));
  end

  // Expected TDO word and post-update register value for a scan of n bits.
  function automatic void model_expect(input logic ir, input int n, input logic [DW-1:0] data,
                                       output logic [DW-1:0] rsp, output logic [6:0] nv,
                                       output int len);
    logic [6:0] v;
    if (ir) begin
      len = 4; v = {3'b000, m_ir};
    end else if (m_ir == 4'd5) begin
      len = 5; v = {2'b00, m_r5};
    end else if (m_ir == 4'd7) begin
      len = 7; v = m_r7;
    end else begin
      len = 1; v = 7'd0;
    end
    rsp = '0;
    for (int i = 0; i < n; i++) begin
      if (i < len) rsp[i] = v[i];
      else         rsp[i] = data[i-len];
    end
    nv = '0;
    for (int j = 0; j < len; j++) begin
      if (j + n < len) nv[j] = v[j+n];
      else             nv[j] = data[j+n-len];
    end
  endfunction

  // Called at a negedge with RST high; releases it and checks the preamble.
  task automatic do_preamble();
    RST = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check_val($sformatf("pre_tms[%0d]", k), 32'(TMS), 32'(k < 5));
      check_val("pre_ready", 32'(cmd_ready), 32'd0);
      check_val("pre_rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge TCK);
    end
    check_val("pre_done_ready", 32'(cmd_ready), 32'd1);
    check_val("pre_done_tap", 32'(tap_state), 32'd1);
    check_val("pre_done_model", 32'(m_st), 32'd1);
    track_en = 1'b1;
  endtask

  task automatic run_cmd(input logic ir, input int len, input logic [DW-1:0] data,
                         input int hold, input int abort_at);
    int            n;
    int            i;
    int            guard;
    int            rlen;
    logic [DW-1:0] rsp_exp;
    logic [6:0]    nv;
    n = len + 1;
    model_expect(ir, n, data, rsp_exp, nv, rlen);
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 20) begin
      @(negedge TCK);
      guard++;
    end
    check_val("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_ir    = ir;
    cmd_len   = LW'(len);
    cmd_data  = data;
    @(negedge TCK);
    cmd_valid = 1'b0;
    cmd_ir    = ~ir;
    cmd_len   = ~LW'(len);
    cmd_data  = ~data;

    exp_tms.push_back(1'b1); exp_tdi.push_back(1'b0);
    if (ir) begin exp_tms.push_back(1'b1); exp_tdi.push_back(1'b0); end
    exp_tms.push_back(1'b0); exp_tdi.push_back(1'b0);
    exp_tms.push_back(1'b0); exp_tdi.push_back(1'b0);
    for (int k = 0; k < n; k++) begin
      exp_tms.push_back(k == n - 1); exp_tdi.push_back(data[k]);
    end
    exp_tms.push_back(1'b1); exp_tdi.push_back(1'b0);
    exp_tms.push_back(1'b0); exp_tdi.push_back(1'b0);

    i = 0;
    while (exp_tms.size() > 0) begin
      if (i == abort_at) begin
        track_en = 1'b0;
        RST = 1'b1;
        #1;
        check_val("abort_tms", 32'(TMS), 32'd1);
        check_val("abort_tdi", 32'(TDI), 32'd0);
        check_val("abort_ready", 32'(cmd_ready), 32'd0);
        check_val("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("abort_rsp_data", 32'(rsp_data), 32'd0);
        check_val("abort_tap", 32'(tap_state), 32'd0);
        exp_tms.delete();
        exp_tdi.delete();
        @(negedge TCK);
        @(negedge TCK);
        do_preamble();
        for (int k = 0; k < 4; k++) begin
          check_val("abort_no_rsp", 32'(rsp_valid), 32'd0);
          @(negedge TCK);
        end
        return;
      end
      check_val($sformatf("tms[%0d]", i), 32'(TMS), 32'(exp_tms.pop_front()));
      check_val($sformatf("tdi[%0d]", i), 32'(TDI), 32'(exp_tdi.pop_front()));
      check_val("busy_ready", 32'(cmd_ready), 32'd0);
      check_val("busy_rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge TCK);
      i++;
    end

`ifdef JTAG_TDO_CAPTURE_EN
    exp_rsp.push_back(rsp_exp);
    check_val("rsp_valid_on", 32'(rsp_valid), 32'd1);
    for (int h = 0; h < hold; h++) begin
      check_val("hold_valid", 32'(rsp_valid), 32'd1);
      check_val("hold_data", 32'(rsp_data), 32'(exp_rsp[0]));
      check_val("hold_ready", 32'(cmd_ready), 32'd0);
      check_val("hold_tms", 32'(TMS), 32'd0);
      @(negedge TCK);
    end
    rsp_ready = 1'b1;
    check_val("rsp_data", 32'(rsp_data), 32'(exp_rsp.pop_front()));
    @(negedge TCK);
    rsp_ready = 1'b0;
    check_val("rsp_valid_off", 32'(rsp_valid), 32'd0);
    check_val("ready_after_rsp", 32'(cmd_ready), 32'd1);
`else
    check_val("no_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("no_rsp_data", 32'(rsp_data), 32'd0);
    check_val("ready_after_scan", 32'(cmd_ready), 32'd1);
    for (int h = 0; h < hold; h++) begin
      @(negedge TCK);
      check_val("idle_no_rsp", 32'(rsp_valid), 32'd0);
    end
`endif

    if (ir)              check_val("ir_reg", 32'(m_ir), 32'(nv[3:0]));
    else if (rlen == 5)  check_val("dr5_reg", 32'(m_r5), 32'(nv[4:0]));
    else if (rlen == 7)  check_val("dr7_reg", 32'(m_r7), 32'(nv));
    check_val("tap_rti", 32'(tap_state), 32'd1);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: run exceeded time limit after %0d comparisons", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin : main
    @(negedge TCK);
    @(negedge TCK);
    check_val("rst_tms", 32'(TMS), 32'd1);
    check_val("rst_tdi", 32'(TDI), 32'd0);
    check_val("rst_ready", 32'(cmd_ready), 32'd0);
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_rsp_data", 32'(rsp_data), 32'd0);
    check_val("rst_tap", 32'(tap_state), 32'd0);
    do_preamble();

    run_cmd(1'b1, 3, 8'h05, 0, -1);
    check_val("ir_is_5", 32'(m_ir), 32'd5);
    run_cmd(1'b0, 4, 8'h16, 10, -1);
    check_val("r5_10110", 32'(m_r5), 32'b10110);
    run_cmd(1'b0, 4, 8'h0B, 0, -1);
    run_cmd(1'b1, 3, 8'h07, 2, -1);
    run_cmd(1'b0, 6, 8'h35, 1, -1);
    run_cmd(1'b0, 7, 8'hC3, 0, -1);
    run_cmd(1'b0, 0, 8'h01, 3, -1);
    // Reset lands in the third shift cycle of this DR scan (index 3 + 2).
    run_cmd(1'b0, 5, 8'h2A, 0, 5);
    run_cmd(1'b1, 3, 8'h05, 0, -1);
    run_cmd(1'b0, 4, 8'h1F, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
